// File: rtl/mesm6_io_master_pkg.sv
// Shared constants and types for the MESM-6 peripheral register bus.
package mesm6_io_master_pkg;

    localparam int IO_ADDR_W   = 15;
    localparam int IO_DATA_W   = 48;
    localparam int IO_REG_BITS = 3;

    typedef enum logic [1:0] {
        IDLE,
        STROBE,
        WAIT,
        RESP
    } io_state_t;

endpackage

// File: rtl/mesm6_io_master.sv
// MESM-6 peripheral bus initiator: takes one CPU I/O request at a time,
// strobes the addressed slot for one cycle and waits (bounded) for its done.
module mesm6_io_master
    import mesm6_io_master_pkg::*;
#(
    parameter int NSLOTS  = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [IO_ADDR_W-1:0]        cpu_addr,
    input  logic                        cpu_read,
    input  logic                        cpu_write,
    input  logic [IO_DATA_W-1:0]        cpu_wdata,
    output logic [IO_DATA_W-1:0]        cpu_rdata,
    output logic                        cpu_done,
    output logic                        cpu_error,
    output logic [IO_ADDR_W-1:0]        io_addr,
    output logic [IO_DATA_W-1:0]        io_wdata,
    output logic [NSLOTS-1:0]           io_read,
    output logic [NSLOTS-1:0]           io_write,
    input  logic [NSLOTS*IO_DATA_W-1:0] io_rdata,
    input  logic [NSLOTS-1:0]           io_done
);

    localparam int SB = (NSLOTS > 1) ? $clog2(NSLOTS) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT);

    io_state_t      state;
    logic [SB-1:0]  slot_q;
    logic [CW-1:0]  cnt;

    function automatic logic [SB-1:0] slot_of(input logic [IO_ADDR_W-1:0] a);
        return a[IO_REG_BITS +: SB];
    endfunction

    function automatic logic req_legal(input logic [IO_ADDR_W-1:0] a,
                                       input logic rd, input logic wr);
        logic upper_ok;
        logic slot_ok;
        upper_ok = (a >> (IO_REG_BITS + SB)) == '0;
        slot_ok  = 32'(slot_of(a)) < NSLOTS;
        return upper_ok && slot_ok && !(rd && wr);
    endfunction

    // Request/strobe/wait/response sequencer with registered bus and CPU outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            slot_q    <= '0;
            cnt       <= '0;
            cpu_rdata <= '0;
            cpu_done  <= 1'b0;
            cpu_error <= 1'b0;
            io_addr   <= '0;
            io_wdata  <= '0;
            io_read   <= '0;
            io_write  <= '0;
        end else begin
            io_read   <= '0;
            io_write  <= '0;
            cpu_done  <= 1'b0;
            cpu_error <= 1'b0;
            cpu_rdata <= '0;
            case (state)
                IDLE: begin
                    if (cpu_read || cpu_write) begin
                        io_addr  <= cpu_addr;
                        io_wdata <= cpu_wdata;
                        slot_q   <= slot_of(cpu_addr);
                        if (req_legal(cpu_addr, cpu_read, cpu_write)) begin
                            state <= STROBE;
                            if (cpu_write)
                                io_write <= NSLOTS'(1) << slot_of(cpu_addr);
                            else
                                io_read  <= NSLOTS'(1) << slot_of(cpu_addr);
                        end else begin
                            state     <= RESP;
                            cpu_done  <= 1'b1;
                            cpu_error <= 1'b1;
                        end
                    end
                end
                STROBE: begin
                    state <= WAIT;
                    cnt   <= '0;
                end
                WAIT: begin
                    if (io_done[slot_q]) begin
                        cpu_rdata <= io_rdata[slot_q*IO_DATA_W +: IO_DATA_W];
                        cpu_done  <= 1'b1;
                        state     <= RESP;
                    end else if (cnt == CNT_LAST) begin
                        cpu_done  <= 1'b1;
                        cpu_error <= 1'b1;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mesm6_io_master.sv
// Randomised scoreboard bench for mesm6_io_master with modelled peripheral slots.
module tb_mesm6_io_master;

    localparam int NS = 4;
    localparam int TO = 8;
    localparam int DW = 48;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [14:0]       cpu_addr = '0;
    logic              cpu_read = 1'b0;
    logic              cpu_write = 1'b0;
    logic [DW-1:0]     cpu_wdata = '0;
    logic [DW-1:0]     cpu_rdata;
    logic              cpu_done;
    logic              cpu_error;
    logic [14:0]       io_addr;
    logic [DW-1:0]     io_wdata;
    logic [NS-1:0]     io_read;
    logic [NS-1:0]     io_write;
    logic [NS*DW-1:0]  io_rdata = '0;
    logic [NS-1:0]     io_done = '0;

    mesm6_io_master #(.NSLOTS(NS), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .cpu_addr(cpu_addr), .cpu_read(cpu_read), .cpu_write(cpu_write),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_done(cpu_done),
        .cpu_error(cpu_error), .io_addr(io_addr), .io_wdata(io_wdata),
        .io_read(io_read), .io_write(io_write), .io_rdata(io_rdata),
        .io_done(io_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            t_done;
        logic          err;
        logic          chk_data;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          sb[$];
    int            n_chk = 0;
    int            n_fail = 0;
    logic [DW-1:0] pmem[NS][8];
    logic [DW-1:0] rmem[NS][8];
    int            done_cyc[NS];
    int            cur_slot = -1;
    int            stale_cyc = -1;
    int            exp_strobe_cyc = -1;
    logic [NS-1:0] exp_rd_vec = '0;
    logic [NS-1:0] exp_wr_vec = '0;
    logic [14:0]   exp_addr = '0;
    logic [DW-1:0] exp_wdata = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Peripheral slots: registers written on strobe, combinational read data,
    // scheduled done pulses, stale pulses and random done noise on other slots.
    always @(negedge clk) begin
        for (int k = 0; k < NS; k++)
            if (io_write[k]) pmem[k][io_addr[2:0]] = io_wdata;
        for (int k = 0; k < NS; k++)
            io_rdata[k*DW +: DW] = pmem[k][io_addr[2:0]];
        for (int k = 0; k < NS; k++)
            io_done[k] = (cyc == done_cyc[k]) ||
                         (k == cur_slot && cyc == stale_cyc) ||
                         (k != cur_slot && $urandom_range(0, 1) == 1);
    end

    // Monitor: strobe shape every cycle, and response checks against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        chk("io_read", io_read, (cyc == exp_strobe_cyc) ? exp_rd_vec : '0);
        chk("io_write", io_write, (cyc == exp_strobe_cyc) ? exp_wr_vec : '0);
        if (cyc == exp_strobe_cyc) begin
            chk("io_addr", io_addr, exp_addr);
            chk("io_wdata", io_wdata, exp_wdata);
        end
        if (cpu_done) begin
            if (sb.size() == 0) begin
                chk("unexpected_cpu_done", cpu_done, 0);
            end else begin
                e = sb.pop_front();
                chk("done_cycle", cyc, e.t_done);
                chk("cpu_error", cpu_error, e.err);
                if (e.chk_data) chk("cpu_rdata", cpu_rdata, e.data);
            end
        end else begin
            chk("idle_rdata", cpu_rdata, 0);
            chk("idle_error", cpu_error, 0);
            if (sb.size() > 0 && cyc > sb[0].t_done) begin
                chk("missing_cpu_done", cpu_done, 1);
                void'(sb.pop_front());
            end
        end
    end

    // Issue one request, predict its outcome and hold it until cpu_done.
    // d: cycles from strobe to the slot's done pulse (0 = never responds).
    task automatic txn(input logic [14:0] a, input logic rd, input logic wr,
                       input logic [DW-1:0] wd, input int d, input bit stale);
        int   t;
        int   s;
        int   w;
        bit   legal;
        exp_t e;
        @(negedge clk); #1;
        t = cyc;
        s = int'(a[4:3]);
        legal = (a[14:5] == 10'd0) && !(rd && wr);
        e.chk_data = 1'b0;
        e.data = '0;
        if (!legal) begin
            e.t_done = t + 1;
            e.err = 1'b1;
        end else begin
            exp_strobe_cyc = t + 1;
            exp_rd_vec = rd ? (NS'(1) << s) : '0;
            exp_wr_vec = wr ? (NS'(1) << s) : '0;
            exp_addr = a;
            exp_wdata = wd;
            if (wr) rmem[s][a[2:0]] = wd;
            if (d > 0 && d - 1 <= TO) begin
                e.t_done = t + 2 + d;
                e.err = 1'b0;
                e.chk_data = rd;
                e.data = rmem[s][a[2:0]];
            end else begin
                e.t_done = t + TO + 3;
                e.err = 1'b1;
                e.chk_data = 1'b1;
                e.data = '0;
            end
            done_cyc[s] = (d > 0) ? t + 1 + d : -1;
        end
        cur_slot = s;
        stale_cyc = stale ? t + 1 : -1;
        sb.push_back(e);
        cpu_addr = a;
        cpu_read = rd;
        cpu_write = wr;
        cpu_wdata = wd;
        w = 0;
        do begin
            @(negedge clk); #1;
            w++;
        end while (!cpu_done && w < 400);
        if (!cpu_done) chk("txn_no_done", cpu_done, 1);
        cpu_read = 1'b0;
        cpu_write = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] v;
        logic [14:0] a;
        logic        rd;
        logic        wr;
        int          d;
        int          t;
        int          r;
        for (int k = 0; k < NS; k++) begin
            done_cyc[k] = -1;
            for (int j = 0; j < 8; j++) begin
                v = {$urandom, $urandom};
                pmem[k][j] = v[DW-1:0];
                rmem[k][j] = v[DW-1:0];
            end
        end
        pmem[0][6] = 48'h123456789ABC;
        rmem[0][6] = 48'h123456789ABC;

        // Reset state.
        repeat (3) @(negedge clk);
        #1;
        chk("rst_cpu_done", cpu_done, 0);
        chk("rst_io_read", io_read, 0);
        chk("rst_io_write", io_write, 0);
        chk("rst_io_addr", io_addr, 0);
        chk("rst_io_wdata", io_wdata, 0);
        reset = 1'b0;

        // GPIO-style read, registered done.
        txn(15'o6, 1'b1, 1'b0, '0, 1, 1'b0);
        // Write then read back.
        txn(15'o7, 1'b0, 1'b1, 48'hFF, 1, 1'b0);
        txn(15'o7, 1'b1, 1'b0, '0, 1, 1'b0);
        // Timeout on a silent slot, then a late done landing in IDLE.
        txn(15'o10, 1'b1, 1'b0, '0, 0, 1'b0);
        txn(15'o10, 1'b1, 1'b0, '0, TO + 3, 1'b0);
        txn(15'o11, 1'b1, 1'b0, '0, 1, 1'b0);
        // Illegal requests.
        txn(15'o40000, 1'b1, 1'b0, '0, 1, 1'b0);
        txn(15'o5, 1'b1, 1'b1, 48'h5A5A, 1, 1'b0);
        // Stale done during strobe, completion only in WAIT; wait-count edges.
        txn(15'o12, 1'b1, 1'b0, '0, 2, 1'b1);
        txn(15'o13, 1'b1, 1'b0, '0, TO + 1, 1'b0);
        txn(15'o14, 1'b1, 1'b0, '0, TO + 2, 1'b0);

        // Reset while waiting drops the access.
        @(negedge clk); #1;
        t = cyc;
        exp_strobe_cyc = t + 1;
        exp_rd_vec = 4'b0100;
        exp_wr_vec = '0;
        exp_addr = 15'o21;
        exp_wdata = '0;
        cur_slot = 2;
        stale_cyc = -1;
        done_cyc[2] = -1;
        cpu_addr = 15'o21;
        cpu_read = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        reset = 1'b1;
        cpu_read = 1'b0;
        @(negedge clk); #1;
        chk("midrst_cpu_done", cpu_done, 0);
        chk("midrst_cpu_error", cpu_error, 0);
        chk("midrst_cpu_rdata", cpu_rdata, 0);
        chk("midrst_io_read", io_read, 0);
        chk("midrst_io_write", io_write, 0);
        chk("midrst_io_addr", io_addr, 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        txn(15'o3, 1'b1, 1'b0, '0, 1, 1'b0);

        // Randomised traffic.
        for (int n = 0; n < 80; n++) begin
            a = 15'($urandom_range(0, 31));
            if ($urandom_range(0, 99) < 8) a[14:5] = 10'($urandom_range(1, 1023));
            r = $urandom_range(0, 9);
            rd = (r == 0) || (r < 5);
            wr = (r == 0) || (r >= 5);
            r = $urandom_range(0, 19);
            d = (r == 0) ? 0 : (r == 1) ? TO + 1 : (r == 2) ? TO + 2 : $urandom_range(1, 4);
            v = {$urandom, $urandom};
            txn(a, rd, wr, v[DW-1:0], d, $urandom_range(0, 3) == 0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (TO + 6) @(negedge clk);
        #1;
        chk("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
